// File: rtl/shared_adder_arb_pkg.sv
// Shared types for the two-core bit-serial adder arbiter.
package shared_adder_arb_pkg;
  typedef enum logic {IDLE = 1'b0, ADD = 1'b1} state_t;
  typedef enum logic {CORE0 = 1'b0, CORE1 = 1'b1} core_t;
endpackage

// File: rtl/shared_adder_arb_fa_bit.sv
// Single full-adder slice of the shared serial datapath, built from two half adders.
module ha_bit (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s0, c0, c1;

  ha_bit u_ha0 (.a(a),  .b(b),   .s(s0), .c(c0));
  ha_bit u_ha1 (.a(s0), .b(cin), .s(s),  .c(c1));

  assign cout = c0 | c1;
endmodule

// File: rtl/shared_adder_arb.sv
// Round-robin arbiter that time-shares one full-adder slice between two cores,
// adding WIDTH-bit operands LSB first over WIDTH cycles.
module shared_adder_arb
  import shared_adder_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             Cin0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  input  logic             Cin1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] Y,
  output logic             Cout,
  output logic             busy
);
  state_t             state_q, state_d;
  core_t              last_q, last_d, win;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, y_q, y_d;
  logic               carry_q, carry_d, cout_q, cout_d, busy_q, busy_d;
  logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d, done0_q, done0_d, done1_q, done1_d;
  logic               eff0, eff1, fa_s, fa_co;

  fa_bit u_fa (.a(a_q[0]), .b(b_q[0]), .cin(carry_q), .s(fa_s), .cout(fa_co));

  // A core is ignored in its own done cycle so a late-dropped req is not re-served.
  assign eff0 = req0 & ~done0_q;
  assign eff1 = req1 & ~done1_q;
  assign win  = (eff0 & eff1) ? ((last_q == CORE0) ? CORE1 : CORE0)
                              : (eff1 ? CORE1 : CORE0);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    y_d     = y_q;
    cout_d  = cout_q;
    busy_d  = busy_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (eff0 | eff1) begin
          state_d = ADD;
          cnt_d   = '0;
          busy_d  = 1'b1;
          last_d  = win;
          if (win == CORE1) begin
            a_d     = A1;
            b_d     = B1;
            carry_d = Cin1;
            gnt1_d  = 1'b1;
          end else begin
            a_d     = A0;
            b_d     = B0;
            carry_d = Cin0;
            gnt0_d  = 1'b1;
          end
        end
      end
      ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH-1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          y_d     = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_co;
          if (last_q == CORE1) done1_d = 1'b1;
          else                 done0_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= CORE1;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      y_q     <= '0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      y_q     <= y_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign Y     = y_q;
  assign Cout  = cout_q;
  assign busy  = busy_q;
endmodule

// File: tb/tb_shared_adder_arb.sv
// Randomized scoreboard bench: a timing/arithmetic model predicts grants and results.
module tb_shared_adder_arb;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req0 = 1'b0, req1 = 1'b0, Cin0 = 1'b0, Cin1 = 1'b0;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic         gnt0, gnt1, done0, done1, Cout, busy;
  logic [W-1:0] Y;

  always #5 clk = ~clk;

  shared_adder_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .A0(A0), .B0(B0), .Cin0(Cin0),
    .req1(req1), .A1(A1), .B1(B1), .Cin1(Cin1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .Y(Y), .Cout(Cout), .busy(busy)
  );

  typedef struct {
    int           core;
    int           at_edge;
    logic [W-1:0] y;
    logic         c;
  } exp_t;

  exp_t         gq[$];
  exp_t         rq[$];
  int           edge_cnt = 0;
  int           checks = 0;
  int           failures = 0;
  int           free_at = 0;
  int           last = 1;
  int           done_e[2] = '{-10, -10};
  int           cap_edge = -100;
  int           rst_edge = -1;
  logic [W-1:0] hold_y = '0;
  logic         hold_c = 1'b0;

  always @(posedge clk) edge_cnt++;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s edge=%0d got=%0h expected=%0h", nm, edge_cnt, act, exp);
    end
  endfunction

  // Predict what happens at the coming rising edge from the current inputs.
  function automatic void model_step();
    int   n, w, s;
    bit   e0, e1;
    exp_t e;
    n = edge_cnt + 1;
    if (rst) begin
      while (gq.size() > 0 && gq[$].at_edge >= n) void'(gq.pop_back());
      while (rq.size() > 0 && rq[$].at_edge >= n) void'(rq.pop_back());
      done_e   = '{-10, -10};
      free_at  = n + 1;
      last     = 1;
      cap_edge = -100;
      rst_edge = n;
    end else if (n >= free_at) begin
      e0 = req0 && (done_e[0] != n - 1);
      e1 = req1 && (done_e[1] != n - 1);
      if (e0 || e1) begin
        w = (e0 && e1) ? 1 - last : (e1 ? 1 : 0);
        s = w ? int'(A1) + int'(B1) + int'(Cin1) : int'(A0) + int'(B0) + int'(Cin0);
        e.core = w; e.at_edge = n; e.y = '0; e.c = 1'b0;
        gq.push_back(e);
        e.at_edge = n + W; e.y = s[W-1:0]; e.c = s[W];
        rq.push_back(e);
        done_e[w] = n + W;
        free_at   = n + W + 1;
        last      = w;
        cap_edge  = n;
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [1:0] eg, ed;
    exp_t       e;
    if (rst_edge >= 0 && edge_cnt >= rst_edge) begin
      if (edge_cnt == rst_edge) begin hold_y = '0; hold_c = 1'b0; end
      eg = 2'b00;
      if (gq.size() > 0 && gq[0].at_edge == edge_cnt) begin
        e  = gq.pop_front();
        eg = (e.core == 1) ? 2'b10 : 2'b01;
      end
      if (eg != 2'b00 || {gnt1, gnt0} != 2'b00) chk("gnt{1,0}", 32'({gnt1, gnt0}), 32'(eg));
      ed = 2'b00;
      if (rq.size() > 0 && rq[0].at_edge == edge_cnt) begin
        e      = rq.pop_front();
        ed     = (e.core == 1) ? 2'b10 : 2'b01;
        hold_y = e.y;
        hold_c = e.c;
      end
      if (ed != 2'b00 || {done1, done0} != 2'b00) chk("done{1,0}", 32'({done1, done0}), 32'(ed));
      chk("Y", 32'(Y), 32'(hold_y));
      chk("Cout", 32'(Cout), 32'(hold_c));
      chk("busy", 32'(busy), 32'(edge_cnt >= cap_edge && edge_cnt < cap_edge + W));
    end
  end

  task automatic step(int k = 1);
    for (int i = 0; i < k; i++) begin
      model_step();
      @(negedge clk);
      #1;
    end
  endtask

  task automatic set0(logic r, logic [W-1:0] a, logic [W-1:0] b, logic c);
    req0 = r; A0 = a; B0 = b; Cin0 = c;
  endtask

  task automatic set1(logic r, logic [W-1:0] a, logic [W-1:0] b, logic c);
    req1 = r; A1 = a; B1 = b; Cin1 = c;
  endtask

  initial begin
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    // single requesters, including overflow cases
    set0(1, 8'h0F, 8'h01, 0); step(1); req0 = 0; step(W + 2);
    set1(1, 8'hFF, 8'h01, 0); step(1); req1 = 0; step(W + 2);
    set1(1, 8'h7F, 8'h80, 1); step(1); req1 = 0; step(W + 2);
    // simultaneous arrival after reset
    rst = 1'b1; step(1); rst = 1'b0;
    set0(1, 8'd3, 8'd4, 0); set1(1, 8'd10, 8'd20, 0);
    step(1); req0 = 0; step(W + 1); req1 = 0; step(W + 2);
    // both held: strict alternation
    set0(1, 8'h55, 8'hAA, 1); set1(1, 8'hC3, 8'h3C, 0);
    step(4 * (W + 1) + 2); req0 = 0; req1 = 0; step(W + 2);
    // req0 held through its done cycle
    set0(1, 8'h80, 8'h80, 0); step(2 * (W + 1) + 1); req0 = 0; step(W + 2);
    // reset mid-ADD with counter at 3, then a tie
    set0(1, 8'hF0, 8'h0F, 1); step(1); req0 = 0; step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    set0(1, 8'd1, 8'd2, 0); set1(1, 8'd5, 8'd6, 1);
    step(1); req0 = 0; step(W + 1); req1 = 0; step(W + 2);
    // requests present during reset are not granted
    set0(1, 8'd9, 8'd9, 0); set1(1, 8'd7, 8'd7, 0);
    rst = 1'b1; step(2); rst = 1'b0; step(2 * (W + 1) + 2);
    req0 = 0; req1 = 0; step(W + 2);
    // random traffic with occasional resets
    for (int i = 0; i < 2000; i++) begin
      int p;
      p = (i < 1000) ? 30 : 80;
      set0($urandom_range(0, 99) < p, W'($urandom), W'($urandom), 1'($urandom));
      set1($urandom_range(0, 99) < p, W'($urandom), W'($urandom), 1'($urandom));
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 1'b0; req0 = 0; req1 = 0;
    step(W + 3);
    chk("drain", 32'(gq.size() + rq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
